debugger_encoder: RTL and testbench

DEBUGGER_ENCODER -- requirements
Module: debugger_encoder

---
 rtl/debugger_encoder.sv | 72 +++++++
 tb/tb_debugger_encoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/debugger_encoder.sv
// debugger_encoder: streams a snapshot of NUM_WORDS debug words as a UART byte frame
// (header, count, words MSB first, XOR checksum) over a valid/ready byte handshake.
module debugger_encoder #(
  parameter int          NUM_WORDS = 8,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word_data,
  output logic [7:0]  word_idx,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, HDR, CNT, LOAD, DATA, CHK, FIN} state_t;
  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);
  state_t      r_state, w_next;
  logic [31:0] r_shift;
  logic [7:0]  r_chk;
  logic [1:0]  r_bcnt;
  logic        w_xfer, w_word_end;
  assign w_xfer     = tx_valid && tx_ready;
  assign w_word_end = r_state == DATA && w_xfer && r_bcnt == 2'd3;
  always_ff @(posedge clk)
    r_state <= !reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? HDR : IDLE;
      HDR:     w_next = w_xfer ? CNT : HDR;
      CNT:     w_next = w_xfer ? LOAD : CNT;
      LOAD:    w_next = DATA;
      DATA:    w_next = !w_word_end ? DATA : (word_idx == LAST_IDX ? CHK : LOAD);
      CHK:     w_next = w_xfer ? FIN : CHK;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    tx_valid = r_state == HDR || r_state == CNT || r_state == DATA || r_state == CHK;
    tx_data  = r_state == HDR  ? HEADER :
               r_state == CNT  ? LAST_IDX + 8'd1 :
               r_state == DATA ? r_shift[31:24] :
               r_state == CHK  ? r_chk : 8'h00;
    busy     = r_state != IDLE;
    done     = r_state == FIN;
  end
  // word_idx holds at the last word after a frame; it only restarts from the count byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift  <= '0;
      r_chk    <= '0;
      r_bcnt   <= '0;
      word_idx <= '0;
    end else begin
      if (r_state == IDLE && start) r_chk <= '0;
      else if (w_xfer)              r_chk <= r_chk ^ tx_data;
      if (r_state == CNT && w_xfer)               word_idx <= '0;
      else if (w_word_end && word_idx != LAST_IDX) word_idx <= word_idx + 8'd1;
      if (r_state == LOAD) begin
        r_shift <= word_data;
        r_bcnt  <= '0;
      end else if (r_state == DATA && w_xfer) begin
        r_shift <= {r_shift[23:0], 8'h00};
        r_bcnt  <= r_bcnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_debugger_encoder.sv
// tb_debugger_encoder: scoreboard bench over three encoder instances (2, 1 and 255 words).
module tb_debugger_encoder;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        rdy = 1;
  logic [2:0]  st = '0;
  logic [31:0] wd0, wd1, wd2;
  logic [7:0]  idx0, idx1, idx2, d0, d1, d2;
  logic        v0, v1, v2, b0, b1, b2, dn0, dn1, dn2;
  logic [7:0]  idx, d;
  logic        v, b, dn;
  int          sel = 0, mode = 0, cyc = 0;
  int          checks = 0, fails = 0, nbytes = 0, ndone = 0, max_idx = 0;
  logic [7:0]  last_b = '0, p_d = '0;
  logic        p_v = 0, p_r = 0, p_x = 0;
  logic [7:0]  q[$];
  always #5 clk = ~clk;
  debugger_encoder #(.NUM_WORDS(2)) u0 (.clk(clk), .reset(rst_n), .start(st[0]), .word_data(wd0),
    .word_idx(idx0), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy), .busy(b0), .done(dn0));
  debugger_encoder #(.NUM_WORDS(1)) u1 (.clk(clk), .reset(rst_n), .start(st[1]), .word_data(wd1),
    .word_idx(idx1), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy), .busy(b1), .done(dn1));
  debugger_encoder #(.NUM_WORDS(255)) u2 (.clk(clk), .reset(rst_n), .start(st[2]), .word_data(wd2),
    .word_idx(idx2), .tx_data(d2), .tx_valid(v2), .tx_ready(rdy), .busy(b2), .done(dn2));
  function automatic logic [31:0] word_of(input int s, input logic [7:0] i);
    return s == 0 ? (i == 0 ? 32'h11223344 : 32'hAABBCCDD) :
           s == 1 ? 32'h0 : {i, ~i, i ^ 8'h5A, 8'h3C};
  endfunction
  always_comb begin
    wd0 = word_of(0, idx0);
    wd1 = word_of(1, idx1);
    wd2 = word_of(2, idx2);
    idx = sel == 0 ? idx0 : sel == 1 ? idx1 : idx2;
    d   = sel == 0 ? d0 : sel == 1 ? d1 : d2;
    v   = sel == 0 ? v0 : sel == 1 ? v1 : v2;
    b   = sel == 0 ? b0 : sel == 1 ? b1 : b2;
    dn  = sel == 0 ? dn0 : sel == 1 ? dn1 : dn2;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    rdy = mode != 0 ? (cyc % 4 == 0) : 1'b1;
  endtask
  task automatic push_frame(input int s, input int n);
    logic [7:0] x, bt;
    logic [31:0] w;
    q.push_back(8'hA5);
    q.push_back(8'(n));
    x = 8'hA5 ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      w = word_of(s, 8'(i));
      for (int k = 3; k >= 0; k--) begin
        bt = w[k*8 +: 8];
        q.push_back(bt);
        x ^= bt;
      end
    end
    q.push_back(x);
  endtask
  task automatic wait_done(input string tag);
    int t = 0;
    while (dn !== 1'b1 && t < 6000) begin
      cycle();
      t++;
    end
    if (t >= 6000) chk({tag, "_timeout"}, t, 0);
  endtask
  task automatic run_frame(input int s, input int m, input int n);
    sel = s;
    mode = m;
    nbytes = 0;
    ndone = 0;
    max_idx = 0;
    push_frame(s, n);
    st[s] = 1'b1;
    cycle();
    st[s] = 1'b0;
    chk("busy_after_start", b, 1);
    wait_done("frame");
    cycle();
    chk("nbytes", nbytes, 3 + 4 * n);
    chk("ndone", ndone, 1);
    chk("q_empty", q.size(), 0);
    chk("busy_after_fin", b, 0);
  endtask
  // Transfers are judged at the falling edge, on the values the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_v && !p_r) begin
        chk("stall_valid", v, 1);
        chk("stall_data", d, p_d);
      end
      if (v && rdy) begin
        if (q.size() == 0) chk("extra_byte", q.size(), 1);
        else chk("byte", d, q.pop_front());
        nbytes++;
        last_b = d;
      end
      if (dn) begin
        ndone++;
        chk("done_after_chk", p_x, 1);
        chk("done_q_empty", q.size(), 0);
      end
      if (int'(idx) > max_idx) max_idx = int'(idx);
      p_v = v;
      p_r = rdy;
      p_d = d;
      p_x = v && rdy;
    end else begin
      p_v = 0;
      p_x = 0;
    end
  end
  initial begin
    int t;
    repeat (3) cycle();
    chk("rst_valid", v, 0);
    chk("rst_busy", b, 0);
    chk("rst_done", dn, 0);
    chk("rst_idx", idx, 0);
    chk("rst_data", d, 0);
    rst_n = 1;
    cycle();
    run_frame(0, 0, 2);
    chk("basic_chk_byte", last_b, 8'hE3);
    run_frame(0, 1, 2);
    chk("stall_chk_byte", last_b, 8'hE3);
    // start held through most of a stalled frame must not queue a second frame
    sel = 0; mode = 1; nbytes = 0; ndone = 0;
    push_frame(0, 2);
    st[0] = 1'b1;
    repeat (20) cycle();
    st[0] = 1'b0;
    wait_done("hold");
    repeat (30) cycle();
    chk("hold_ndone", ndone, 1);
    chk("hold_nbytes", nbytes, 11);
    chk("hold_busy", b, 0);
    // abort in the middle of word 1
    mode = 0; nbytes = 0; ndone = 0;
    push_frame(0, 2);
    st[0] = 1'b1;
    cycle();
    st[0] = 1'b0;
    t = 0;
    while (!(v && idx == 8'd1) && t < 100) begin
      cycle();
      t++;
    end
    chk("abort_reached", t < 100, 1);
    rst_n = 0;
    cycle();
    chk("abort_valid", v, 0);
    chk("abort_busy", b, 0);
    chk("abort_idx", idx, 0);
    chk("abort_ndone", ndone, 0);
    rst_n = 1;
    q.delete();
    cycle();
    run_frame(0, 0, 2);
    chk("fresh_chk_byte", last_b, 8'hE3);
    run_frame(1, 0, 1);
    chk("n1_chk_byte", last_b, 8'hA4);
    chk("n1_max_idx", max_idx, 0);
    run_frame(2, 0, 255);
    chk("n255_max_idx", max_idx, 254);
    chk("n255_idx_hold", idx, 254);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
